// File: rtl/floo_hbm_req_scheduler.sv
// Round-robin front end for a fixed-latency HBM model: one FIFO of in-flight requests,
// each answered in acceptance order once it has aged Latency cycles.
module floo_hbm_req_scheduler #(
  parameter int unsigned          NumReq         = 4,
  parameter int unsigned          Latency        = 100,
  parameter int unsigned          MaxOutstanding = 8,
  parameter int unsigned          AddrWidth      = 48,
  parameter int unsigned          IdWidth        = 4,
  parameter logic [AddrWidth-1:0] MemSize        = AddrWidth'('h10000),
  parameter logic [31:0]          TimerInit      = 32'h0,
  localparam int unsigned         PortW          = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned         PtrW           = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
  localparam int unsigned         CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq*IdWidth-1:0]   req_id_i,
  input  logic [NumReq-1:0]           req_we_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [IdWidth-1:0]          rsp_id_o,
  output logic                        rsp_we_o,
  output logic                        rsp_err_o,
  output logic [CntW-1:0]             outstanding_o,
  output logic                        busy_o,
  output logic [1:0]                  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid must stay high with stable payload until then, ready may depend on valid.

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic [PortW-1:0]   port;
    logic [IdWidth-1:0] id;
    logic               we;
    logic               err;
    logic [31:0]        stamp;
  } entry_t;

  entry_t               mem_q [MaxOutstanding];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q, rd_next;
  logic [CntW-1:0]      cnt_q, cnt_after_pop;
  logic [31:0]          timer_q, next_stamp, next_age;
  logic [PortW-1:0]     rr_ptr_q, gnt_port, cand;
  logic                 gnt_found, push, pop;
  logic [AddrWidth-1:0] gnt_addr;
  entry_t               head, push_entry;
  state_e               state_q, state_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    gnt_found = 1'b0;
    gnt_port  = '0;
    cand      = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand = PortW'((int'(rr_ptr_q) + i) % int'(NumReq));
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_port  = cand;
      end
    end
  end

  // Admission looks only at the registered count, so a retiring head never frees a slot
  // in the same cycle and rsp_ready has no path to req_ready.
  assign push        = gnt_found && (cnt_q < CntW'(MaxOutstanding));
  assign req_ready_o = push ? (NumReq'(1) << gnt_port) : '0;
  assign gnt_addr    = req_addr_i[gnt_port*AddrWidth +: AddrWidth];

  always_comb begin
    push_entry.port  = gnt_port;
    push_entry.id    = req_id_i[gnt_port*IdWidth +: IdWidth];
    push_entry.we    = req_we_i[gnt_port];
    push_entry.err   = (gnt_addr >= MemSize);
    push_entry.stamp = timer_q;
  end

  assign pop = (state_q == RESP) && rsp_ready_i[head.port];

  // The state register holds the view of the head for the coming cycle, so the next head's
  // age is evaluated one tick ahead; wrap-safe because the age is a modulo difference.
  always_comb begin
    cnt_after_pop = cnt_q - CntW'(pop);
    rd_next       = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    next_stamp    = (cnt_after_pop != '0) ? mem_q[rd_next].stamp : timer_q;
    next_age      = timer_q + 32'd1 - next_stamp;
    state_d       = IDLE;
    if ((cnt_after_pop != '0) || push) begin
      state_d = (next_age >= 32'(Latency)) ? RESP : WAIT;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_id_o    = '0;
    rsp_we_o    = 1'b0;
    rsp_err_o   = 1'b0;
    if (state_q == RESP) begin
      rsp_valid_o[head.port] = 1'b1;
      rsp_id_o               = head.id;
      rsp_we_o               = head.we;
      rsp_err_o              = head.err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q  <= TimerInit;
      rr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      for (int i = 0; i < int'(MaxOutstanding); i++) mem_q[i] <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
      state_q <= state_d;
      cnt_q   <= cnt_q + CntW'(push) - CntW'(pop);
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
        rr_ptr_q        <= (gnt_port == PortW'(NumReq - 1)) ? '0 : gnt_port + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_next;
    end
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = (cnt_q != '0);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_floo_hbm_req_scheduler.sv
// Directed bench for floo_hbm_req_scheduler: arbitration order, latency, error flag,
// backpressure, timer wrap and mid-flight reset.
module tb_floo_hbm_req_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid, req_we, rsp_ready;
  logic [191:0] req_addr;
  logic [15:0]  req_id;
  logic [3:0]   req_ready, rsp_valid, rsp_id, outstanding;
  logic         rsp_we, rsp_err, busy;
  logic [1:0]   dbg_state;
  logic [3:0]   w_req_ready, w_rsp_valid, w_rsp_id, w_outstanding;
  logic         w_rsp_we, w_rsp_err, w_busy;
  logic [1:0]   w_dbg_state;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  floo_hbm_req_scheduler dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_id_i(req_id), .req_we_i(req_we), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_we_o(rsp_we), .rsp_err_o(rsp_err),
    .outstanding_o(outstanding), .busy_o(busy), .dbg_state_o(dbg_state)
  );

  // Same stimulus, timer starting just below the 32-bit wrap.
  floo_hbm_req_scheduler #(.TimerInit(32'hFFFF_FFF0)) dut_w (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(w_req_ready),
    .req_addr_i(req_addr), .req_id_i(req_id), .req_we_i(req_we), .rsp_valid_o(w_rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_id_o(w_rsp_id), .rsp_we_o(w_rsp_we), .rsp_err_o(w_rsp_err),
    .outstanding_o(w_outstanding), .busy_o(w_busy), .dbg_state_o(w_dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_id    = '0;
    rsp_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [3:0] id, input logic [47:0] addr, input logic we);
    req_id[p*4 +: 4]    = id;
    req_addr[p*48 +: 48] = addr;
    req_we[p]           = we;
  endtask

  task automatic send(input int p, input logic [3:0] id, input logic [47:0] addr, input logic we,
                      output int acc);
    int n;
    set_port(p, id, addr, we);
    req_valid[p] = 1'b1;
    acc = -1;
    n = 0;
    while (acc < 0 && n < 300) begin
      @(negedge clk);
      if (req_ready[p]) acc = cyc;
      step();
      n++;
    end
    req_valid[p] = 1'b0;
    total++;
    if (acc < 0) begin
      bad++;
      $display("FAIL send_timeout port=%0d got ready=0 required ready=1", p);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++; if ({rsp_id, rsp_we, rsp_err} !== 6'b0) begin bad++; $display("FAIL reset_rsp_fields got=%b exp=0", {rsp_id, rsp_we, rsp_err}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    step();
  endtask

  task automatic test_single_read();
    int t0, k;
    rsp_ready = 4'hF;
    send(0, 4'd3, 48'h100, 1'b0, t0);
    for (int n = 0; n < 101; n++) begin
      @(negedge clk);
      k = cyc - t0;
      if (k == 1) begin
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
      end
      if (k < 100) begin
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL single_early k=%0d got=%b exp=0000", k, rsp_valid); end
      end else if (k == 100) begin
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_valid got=%b exp=0001", rsp_valid); end
        total++; if ({rsp_id, rsp_we, rsp_err} !== {4'd3, 1'b0, 1'b0}) begin bad++; $display("FAIL single_fields got=%h exp=%h", {rsp_id, rsp_we, rsp_err}, {4'd3, 2'b00}); end
      end else begin
        total++; if (rsp_valid !== 4'b0 || outstanding !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL single_drain got valid=%b outst=%0d busy=%b exp 0000/0/0", rsp_valid, outstanding, busy); end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int t0, k, j;
    logic [3:0] exp_ready;
    do_reset();
    rsp_ready = 4'hF;
    for (int p = 0; p < 4; p++) set_port(p, 4'(p + 4), 48'(256 * p), 1'(p & 1));
    req_valid = 4'hF;
    @(negedge clk);
    t0 = cyc;
    for (int n = 0; n < 110; n++) begin
      if (n > 0) @(negedge clk);
      k = cyc - t0;
      exp_ready = (k < 8) ? 4'(1 << (k % 4)) : 4'b0;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
      if (k == 8) begin
        total++; if (outstanding !== 4'd8) begin bad++; $display("FAIL rr_full got=%0d exp=8", outstanding); end
      end
      if (k >= 100 && k < 108) begin
        j = k - 100;
        total++; if (rsp_valid !== 4'(1 << (j % 4)) || rsp_id !== 4'((j % 4) + 4) || rsp_we !== 1'(j & 1)) begin
          bad++; $display("FAIL rr_rsp k=%0d got v=%b id=%0d we=%b exp v=%b id=%0d we=%b", k, rsp_valid, rsp_id, rsp_we, 4'(1 << (j % 4)), (j % 4) + 4, j & 1);
        end
      end else begin
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL rr_no_rsp k=%0d got=%b exp=0000", k, rsp_valid); end
      end
      if (k == 108) begin
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL rr_drain got=%0d exp=0", outstanding); end
      end
      step();
      if (k == 100) req_valid = 4'b0;
    end
  endtask

  task automatic test_addr_err();
    int t0, t1, k;
    rsp_ready = 4'hF;
    send(2, 4'hA, 48'h10000, 1'b1, t0);
    send(3, 4'hB, 48'h0FFFF, 1'b0, t1);
    total++; if (t1 !== t0 + 1) begin bad++; $display("FAIL err_back_to_back got=%0d exp=%0d", t1, t0 + 1); end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      k = cyc - t0;
      if (k == 100) begin
        total++; if ({rsp_valid, rsp_id, rsp_we, rsp_err} !== {4'b0100, 4'hA, 1'b1, 1'b1}) begin bad++; $display("FAIL err_high got v=%b id=%h we=%b err=%b exp v=0100 id=a we=1 err=1", rsp_valid, rsp_id, rsp_we, rsp_err); end
      end else if (k == 101) begin
        total++; if ({rsp_valid, rsp_id, rsp_we, rsp_err} !== {4'b1000, 4'hB, 1'b0, 1'b0}) begin bad++; $display("FAIL err_low got v=%b id=%h we=%b err=%b exp v=1000 id=b we=0 err=0", rsp_valid, rsp_id, rsp_we, rsp_err); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int acc [8];
    int fport [8];
    logic [3:0] fid [8];
    int t0, k, e;
    do_reset();
    rsp_ready = 4'b1101;
    fport[0] = 1;
    fid[0] = 4'd9;
    for (int i = 1; i < 8; i++) begin
      fport[i] = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 2 : 3);
      fid[i] = 4'(i);
    end
    for (int i = 0; i < 8; i++) send(fport[i], fid[i], 48'(i * 64), 1'(i & 1), acc[i]);
    t0 = acc[0];
    total++; if (acc[7] !== t0 + 7) begin bad++; $display("FAIL bp_fill got=%0d exp=%0d", acc[7], t0 + 7); end
    set_port(0, 4'hC, 48'h80, 1'b0);
    req_valid[0] = 1'b1;
    for (int n = 0; n < 240; n++) begin
      @(negedge clk);
      k = cyc - t0;
      if (k < 100) begin
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL bp_early k=%0d got=%b exp=0000", k, rsp_valid); end
      end else if (k < 120) begin
        total++; if (rsp_valid !== 4'b0010 || rsp_id !== 4'd9 || rsp_we !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL bp_hold k=%0d got v=%b id=%0d exp v=0010 id=9", k, rsp_valid, rsp_id); end
        total++; if (outstanding !== 4'd8 || req_ready !== 4'b0) begin bad++; $display("FAIL bp_stall k=%0d got outst=%0d ready=%b exp 8/0000", k, outstanding, req_ready); end
      end else if (k < 128) begin
        e = k - 120;
        total++; if (rsp_valid !== 4'(1 << fport[e]) || rsp_id !== fid[e] || rsp_we !== 1'(e & 1)) begin bad++; $display("FAIL bp_release k=%0d got v=%b id=%0d exp v=%b id=%0d", k, rsp_valid, rsp_id, 4'(1 << fport[e]), fid[e]); end
      end else if (k < 221) begin
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL bp_gap k=%0d got=%b exp=0000", k, rsp_valid); end
      end else if (k == 221) begin
        total++; if (rsp_valid !== 4'b0001 || rsp_id !== 4'hC) begin bad++; $display("FAIL bp_late got v=%b id=%h exp v=0001 id=c", rsp_valid, rsp_id); end
      end
      if (k == 120) begin
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_retire_ready got=%b exp=0000", req_ready); end
      end
      if (k == 121) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_regrant got=%b exp=0001", req_ready); end
      end
      step();
      if (k == 119) rsp_ready = 4'hF;
      if (k == 121) req_valid[0] = 1'b0;
    end
  endtask

  task automatic test_timer_wrap();
    int t0, k;
    do_reset();
    rsp_ready = 4'hF;
    send(0, 4'd5, 48'h40, 1'b1, t0);
    for (int n = 0; n < 101; n++) begin
      @(negedge clk);
      k = cyc - t0;
      if (k < 100) begin
        total++; if (w_rsp_valid !== 4'b0) begin bad++; $display("FAIL wrap_early k=%0d got=%b exp=0000", k, w_rsp_valid); end
      end else if (k == 100) begin
        total++; if (w_rsp_valid !== 4'b0001 || w_rsp_id !== 4'd5 || w_rsp_we !== 1'b1) begin bad++; $display("FAIL wrap_rsp got v=%b id=%0d we=%b exp v=0001 id=5 we=1", w_rsp_valid, w_rsp_id, w_rsp_we); end
      end else begin
        total++; if (w_rsp_valid !== 4'b0 || w_outstanding !== 4'd0) begin bad++; $display("FAIL wrap_drain got v=%b outst=%0d exp 0000/0", w_rsp_valid, w_outstanding); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    do_reset();
    rsp_ready = 4'hF;
    for (int i = 0; i < 5; i++) send(i % 4, 4'(i + 1), 48'(i * 16), 1'b0, acc);
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    total++; if (outstanding !== 4'd5) begin bad++; $display("FAIL mid_before got=%0d exp=5", outstanding); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++; if (outstanding !== 4'd0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_after got outst=%0d v=%b busy=%b exp 0/0000/0", outstanding, rsp_valid, busy); end
    for (int n = 0; n < 200; n++) begin
      step();
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0 || w_rsp_valid !== 4'b0) begin bad++; $display("FAIL mid_stale n=%0d got v=%b wv=%b exp 0000", n, rsp_valid, w_rsp_valid); end
    end
    step();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_addr_err();
    test_backpressure();
    test_timer_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
